// File: rtl/clb_cfg_loader.sv
// Serial configuration loader: hunts a preamble, reads a 16-bit frame count, then
// deserialises parity-protected 37-bit frames and issues one addressed write per CLB.
module clb_cfg_loader #(
    parameter int unsigned NUM_CLB  = 64,
    parameter int unsigned ADDR_W   = 6,
    parameter logic [7:0]  PREAMBLE = 8'hF2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_din,
    input  logic              i_din_valid,
    output logic [ADDR_W-1:0] o_cfg_addr,
    output logic [36:0]       o_cfg_data,
    output logic              o_cfg_we,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    typedef enum logic [2:0] {
        StHunt, StLen, StStart, StData, StPar, StWrite, StDone, StError
    } state_t;

    state_t            r_state;
    logic [7:0]        r_shift;
    logic [15:0]       r_count;
    logic [5:0]        r_bitcnt;
    logic [36:0]       r_frame;
    logic [ADDR_W-1:0] r_idx;

    logic [7:0]  w_hunt_next;
    logic [15:0] w_cnt_next;
    logic        w_par_ok;
    logic        w_last;

    assign w_hunt_next = {r_shift[6:0], i_din};
    assign w_cnt_next  = {r_count[14:0], i_din};
    assign w_par_ok    = ~(^r_frame ^ i_din);
    assign w_last      = (17'(r_idx) + 17'd1) == {1'b0, r_count};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= StHunt;
            r_shift    <= 8'd0;
            r_count    <= 16'd0;
            r_bitcnt   <= 6'd0;
            r_frame    <= 37'd0;
            r_idx      <= '0;
            o_cfg_addr <= '0;
            o_cfg_data <= 37'd0;
            o_cfg_we   <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_err      <= 1'b0;
        end else begin
            o_cfg_we <= 1'b0;
            case (r_state)
                StHunt: begin
                    if (i_din_valid) begin
                        r_shift <= w_hunt_next;
                        if (w_hunt_next == PREAMBLE) begin
                            r_state  <= StLen;
                            r_bitcnt <= 6'd0;
                            o_busy   <= 1'b1;
                        end
                    end
                end
                StLen: begin
                    if (i_din_valid) begin
                        r_count  <= w_cnt_next;
                        r_bitcnt <= r_bitcnt + 6'd1;
                        if (r_bitcnt == 6'd15) begin
                            r_bitcnt <= 6'd0;
                            if (w_cnt_next == 16'd0) begin
                                r_state <= StDone;
                                o_done  <= 1'b1;
                                o_busy  <= 1'b0;
                            end else if (w_cnt_next > 16'(NUM_CLB)) begin
                                r_state <= StError;
                                o_err   <= 1'b1;
                                o_busy  <= 1'b0;
                            end else begin
                                r_state <= StStart;
                                r_idx   <= '0;
                            end
                        end
                    end
                end
                StStart: begin
                    if (i_din_valid && !i_din) begin
                        r_state  <= StData;
                        r_bitcnt <= 6'd0;
                    end
                end
                StData: begin
                    if (i_din_valid) begin
                        r_frame <= {r_frame[35:0], i_din};
                        if (r_bitcnt == 6'd36) begin
                            r_state  <= StPar;
                            r_bitcnt <= 6'd0;
                        end else begin
                            r_bitcnt <= r_bitcnt + 6'd1;
                        end
                    end
                end
                StPar: begin
                    if (i_din_valid) begin
                        if (w_par_ok) begin
                            r_state <= StWrite;
                        end else begin
                            r_state <= StError;
                            o_err   <= 1'b1;
                            o_busy  <= 1'b0;
                        end
                    end
                end
                StWrite: begin
                    // Write fires regardless of din_valid; a bit arriving now is a START bit.
                    o_cfg_we   <= 1'b1;
                    o_cfg_data <= r_frame;
                    o_cfg_addr <= r_idx;
                    r_idx      <= r_idx + 1'b1;
                    if (w_last) begin
                        r_state <= StDone;
                        o_done  <= 1'b1;
                        o_busy  <= 1'b0;
                    end else if (i_din_valid && !i_din) begin
                        r_state  <= StData;
                        r_bitcnt <= 6'd0;
                    end else begin
                        r_state <= StStart;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_clb_cfg_loader.sv
// Scoreboard bench for clb_cfg_loader: a stream generator predicts writes from the
// frames it sends; a negedge monitor pops and compares every cfg_we pulse.
module tb_clb_cfg_loader;

    localparam int unsigned NUM_CLB  = 64;
    localparam int unsigned ADDR_W   = 6;
    localparam logic [7:0]  PREAMBLE = 8'hF2;

    logic              clk = 1'b0;
    logic              rst;
    logic              din;
    logic              din_valid;
    logic [ADDR_W-1:0] cfg_addr;
    logic [36:0]       cfg_data;
    logic              cfg_we;
    logic              busy;
    logic              done;
    logic              err;

    clb_cfg_loader #(
        .NUM_CLB (NUM_CLB),
        .ADDR_W  (ADDR_W),
        .PREAMBLE(PREAMBLE)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_din      (din),
        .i_din_valid(din_valid),
        .o_cfg_addr (cfg_addr),
        .o_cfg_data (cfg_data),
        .o_cfg_we   (cfg_we),
        .o_busy     (busy),
        .o_done     (done),
        .o_err      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [36:0]       data;
        int                edge_no;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_edge   = 0;
    int   wr_count = 0;
    int   last_edge;
    int   wr_base;
    int   m_n;
    int   m_idx;
    bit   m_alive;

    always @(posedge clk) n_edge++;

    // Monitor: every write must match the oldest predicted write, including its edge.
    always @(negedge clk) begin
        exp_t e;
        if (cfg_we) begin
            wr_count++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got addr=%0d data=%h, required no write",
                         cfg_addr, cfg_data);
            end else begin
                e = exp_q.pop_front();
                if (cfg_addr !== e.addr || cfg_data !== e.data || n_edge != e.edge_no) begin
                    n_fail++;
                    $display("FAIL write: got addr=%0d data=%h edge=%0d, required addr=%0d data=%h edge=%0d",
                             cfg_addr, cfg_data, n_edge, e.addr, e.data, e.edge_no);
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            din_valid = 1'b0;
            din       = 1'($urandom);
        end
    endtask

    task automatic drive(input logic b, input int stall_pct);
        while (int'($urandom_range(99)) < stall_pct) begin
            @(negedge clk);
            din_valid = 1'b0;
            din       = 1'($urandom);
        end
        @(negedge clk);
        din       = b;
        din_valid = 1'b1;
        last_edge = n_edge;
    endtask

    task automatic send_bits(input logic [31:0] v, input int nbits, input int stall_pct);
        for (int i = nbits - 1; i >= 0; i--) drive(v[i], stall_pct);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        din_valid = 1'b0;
        idle(2);
        rst = 1'b0;
        exp_q.delete();
        m_alive = 1'b0;
        wr_base = wr_count;
    endtask

    task automatic start_load(input logic [15:0] n, input int stall_pct);
        send_bits({24'd0, PREAMBLE}, 8, stall_pct);
        send_bits({16'd0, n}, 16, stall_pct);
        m_n     = int'(n);
        m_idx   = 0;
        m_alive = (n != 16'd0) && (n <= 16'(NUM_CLB));
    endtask

    // Frame i of a load targets address i; a bad parity kills the rest of the load.
    task automatic send_frame(input logic [36:0] p, input bit good, input int stall_pct,
                              input int n_idle, input bit stall_wr);
        exp_t e;
        logic par;
        repeat (n_idle) drive(1'b1, stall_pct);
        drive(1'b0, stall_pct);
        for (int i = 36; i >= 0; i--) drive(p[i], stall_pct);
        par = (^p) ^ !good;
        drive(par, stall_pct);
        if (m_alive) begin
            if (good) begin
                e.addr    = ADDR_W'(m_idx);
                e.data    = p;
                e.edge_no = last_edge + 2;
                exp_q.push_back(e);
                m_idx++;
                if (m_idx == m_n) m_alive = 1'b0;
            end else begin
                m_alive = 1'b0;
            end
        end
        if (stall_wr) begin
            @(negedge clk);
            din_valid = 1'b0;
        end
    endtask

    function automatic bit first_match_at_end(input logic [27:0] s);
        logic [7:0] sh = 8'd0;
        for (int i = 27; i >= 0; i--) begin
            sh = {sh[6:0], s[i]};
            if (sh == PREAMBLE) return (i == 0);
        end
        return 1'b0;
    endfunction

    task automatic check_flags(input string tag, input logic b, input logic d, input logic e);
        check({tag, "_busy"}, 64'(busy), 64'(b));
        check({tag, "_done"}, 64'(done), 64'(d));
        check({tag, "_err"}, 64'(err), 64'(e));
    endtask

    initial begin
        logic [27:0] hs;
        logic [31:0] r;
        logic [36:0] p;

        rst       = 1'b1;
        din       = 1'b0;
        din_valid = 1'b0;
        m_alive   = 1'b0;
        idle(3);
        check("reset_addr", 64'(cfg_addr), 64'd0);
        check("reset_data", 64'(cfg_data), 64'd0);
        check("reset_we", 64'(cfg_we), 64'd0);
        check_flags("reset", 1'b0, 1'b0, 1'b0);
        rst     = 1'b0;
        wr_base = wr_count;

        // Random noise then preamble, count 0.
        do begin
            r  = $urandom;
            hs = {r[19:0], PREAMBLE};
        end while (!first_match_at_end(hs));
        send_bits({4'd0, hs}, 28, 0);
        idle(1);
        check("count0_busy_after_preamble", 64'(busy), 64'd1);
        send_bits(32'd0, 16, 0);
        idle(3);
        check_flags("count0", 1'b0, 1'b1, 1'b0);
        check("count0_writes", 64'(wr_count - wr_base), 64'd0);

        // Two frames, no stalls.
        do_reset();
        start_load(16'd2, 0);
        send_frame(37'h00_0001_0000, 1'b1, 0, 0, 1'b0);
        send_frame(37'h1F_FFFF_FFFF, 1'b1, 0, 3, 1'b0);
        idle(3);
        check_flags("two_frames", 1'b0, 1'b1, 1'b0);
        check("two_frames_writes", 64'(wr_count - wr_base), 64'd2);
        check("two_frames_pending", 64'(exp_q.size()), 64'd0);

        // Same stream with ~50% stalls, and din_valid=0 on the first write edge.
        do_reset();
        start_load(16'd2, 50);
        send_frame(37'h00_0001_0000, 1'b1, 50, 0, 1'b1);
        send_frame(37'h1F_FFFF_FFFF, 1'b1, 50, 3, 1'b0);
        idle(3);
        check_flags("stalled", 1'b0, 1'b1, 1'b0);
        check("stalled_writes", 64'(wr_count - wr_base), 64'd2);
        check("stalled_pending", 64'(exp_q.size()), 64'd0);

        // Bad parity on frame 0; later good frames must be ignored.
        do_reset();
        start_load(16'd3, 0);
        send_frame(37'h0A_5A5A_5A5A, 1'b0, 0, 0, 1'b0);
        idle(2);
        check_flags("badpar", 1'b0, 1'b0, 1'b1);
        send_frame(37'h01_2345_6789, 1'b1, 0, 1, 1'b0);
        send_frame(37'h1E_DCBA_9876, 1'b1, 0, 0, 1'b0);
        idle(3);
        check_flags("badpar_after", 1'b0, 1'b0, 1'b1);
        check("badpar_writes", 64'(wr_count - wr_base), 64'd0);
        do_reset();
        check_flags("badpar_rst", 1'b0, 1'b0, 1'b0);

        // Count NUM_CLB+1 is rejected right after the last count bit.
        start_load(16'(NUM_CLB + 1), 0);
        idle(1);
        check_flags("count65", 1'b0, 1'b0, 1'b1);
        send_frame(37'h00_0000_0001, 1'b1, 0, 0, 1'b0);
        idle(3);
        check("count65_writes", 64'(wr_count - wr_base), 64'd0);

        // Full NUM_CLB-frame load with random payloads, idle fill and stalls.
        do_reset();
        start_load(16'(NUM_CLB), 30);
        for (int f = 0; f < int'(NUM_CLB); f++) begin
            p = 37'({$urandom, $urandom});
            send_frame(p, 1'b1, 30, int'($urandom_range(2)), 1'($urandom));
        end
        idle(3);
        check_flags("full", 1'b0, 1'b1, 1'b0);
        check("full_writes", 64'(wr_count - wr_base), 64'(NUM_CLB));
        check("full_last_addr", 64'(cfg_addr), 64'(NUM_CLB - 1));
        check("full_pending", 64'(exp_q.size()), 64'd0);

        // Reset in the middle of frame 3's data, then a fresh load from address 0.
        do_reset();
        start_load(16'd5, 20);
        for (int f = 0; f < 3; f++) send_frame(37'({$urandom, $urandom}), 1'b1, 20, 1, 1'b0);
        p = 37'({$urandom, $urandom});
        drive(1'b0, 0);
        for (int i = 36; i > 16; i--) drive(p[i], 0);
        check("midrst_writes_before", 64'(wr_count - wr_base), 64'd3);
        @(negedge clk);
        rst       = 1'b1;
        din_valid = 1'b0;
        @(negedge clk);
        check("midrst_addr", 64'(cfg_addr), 64'd0);
        check("midrst_data", 64'(cfg_data), 64'd0);
        check("midrst_we", 64'(cfg_we), 64'd0);
        check_flags("midrst", 1'b0, 1'b0, 1'b0);
        check("midrst_pending", 64'(exp_q.size()), 64'd0);
        rst     = 1'b0;
        m_alive = 1'b0;
        wr_base = wr_count;
        start_load(16'd3, 20);
        for (int f = 0; f < 3; f++) send_frame(37'({$urandom, $urandom}), 1'b1, 20, 0, 1'b0);
        idle(3);
        check_flags("reload", 1'b0, 1'b1, 1'b0);
        check("reload_writes", 64'(wr_count - wr_base), 64'd3);
        check("reload_pending", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clb_cfg_loader.md
Name: clb_cfg_loader

Overview:
- Serial configuration loader that writes the configuration bits of the CLB array.
- Hunts for a preamble in a serial bitstream, reads a 16-bit frame count, then deserialises one parity-protected 37-bit frame per CLB.
- Each good frame is issued as an addressed parallel write on the config bus.
- Sits between the external configuration pin interface and the per-CLB configuration registers. Those registers are mux select fields, LUT memory, combination option, input muxes, DQ muxes and the flop/latch select.

Parameters:
- NUM_CLB, 64, number of CLBs addressable; max legal frame count.
- ADDR_W, 6, width of cfg_addr; must satisfy 2**ADDR_W >= NUM_CLB.
- PREAMBLE, 8'hF2, sync pattern; compared against the last 8 bits received, MSB first.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- din  input  1  serial config bit.
- din_valid  input  1  din is consumed on a clk edge only when this is 1.
- cfg_addr  output  ADDR_W  target CLB index of the current write.
- cfg_data  output  37  frame payload.
- cfg_we  output  1  one-cycle write strobe.
- busy  output  1  high from preamble match until DONE or ERROR.
- done  output  1  sticky; all frames loaded.
- err  output  1  sticky; parity or count error.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: cfg_addr=0, cfg_data=0, cfg_we=0, busy=0, done=0, err=0. Internal state goes to HUNT; shift and bit counters are cleared.
- rst during any state aborts the load. No cfg_we is issued for a partial frame.
- Bit acceptance: a bit is accepted only on an edge with din_valid=1. din_valid=0 stalls every state with no side effects.
- cfg_data layout, MSB first: [36:35] mux2select, [34:33] mux3select, [32:31] mux4select, [30:29] mux5select, [28:27] mux6select, [26:11] mem[15:0], [10:9] comboption, [8:3] {o2m1_0,o2m2_0,o2m3_0,o2m1_1,o2m2_1,o2m3_1}, [2:1] {DQmux1,DQmux2}, [0] floporlatch.
- HUNT state:
  - Shift accepted bits into an 8-bit register.
  - When the register equals PREAMBLE after a shift, go to LEN and set busy=1.
  - Overlapping matches are allowed; there is no bit-alignment assumption.
- LEN state:
  - Collect 16 bits MSB first into the frame count N.
  - N=0: go to DONE (done=1, busy=0), no writes.
  - N>NUM_CLB: go to ERROR.
  - Otherwise go to START with frame index 0.
- START state:
  - A 1 bit is idle fill and is ignored.
  - A 0 bit is the start bit; go to DATA.
- DATA state: collect exactly 37 bits MSB first, then go to PAR.
- PAR state:
  - Accept one even-parity bit. XOR of the 37 data bits and the parity bit must be 0.
  - Parity good:
    - On the next edge, cfg_data=payload, cfg_addr=frame index and cfg_we=1 for exactly one cycle.
    - The write occurs even if din_valid=0 on that edge.
    - Then increment the frame index.
    - If index+1==N, go to DONE; else go to START.
  - Parity bad: go to ERROR. No write is issued.
- Write latency: cfg_we asserts 1 cycle after the edge that accepts the parity bit.
- Bits accepted on the write edge:
  - A bit accepted on the write edge is processed by the next state: a START bit, or nothing in DONE.
  - The loader never loses a bit during the write cycle.
- Output hold: cfg_data and cfg_addr hold their values until the next write.
- DONE state: done=1, busy=0. All further input is ignored until rst.
- ERROR state: err=1, busy=0, done stays 0. All input is ignored until rst.
- Frame index range:
  - The frame index never exceeds N-1 ≤ NUM_CLB-1.
  - A count check at LEN guarantees no address wrap.
  - Writing address NUM_CLB-1 when N=NUM_CLB completes normally into DONE.

Test Plan:
- Reset, then 20 random bits not containing 8'hF2, then preamble F2, count 0x0000 -> busy pulses, done=1, cfg_we never asserted, err=0.
- Preamble, count 0x0002, two frames:
  - Frame 0 payload 37'h0_0001_0000 plus correct parity.
  - 3 idle 1s, then frame 1 payload 37'h1F_FFFF_FFFF plus parity.
  - Response: exactly two cfg_we pulses, (addr 0, 37'h0001_0000) and (addr 1, 37'h1F_FFFF_FFFF); each pulse is 1 cycle after its parity bit; done=1 after the second.
- Same stream with din_valid deasserted randomly ~50% of cycles -> identical writes and final done. A write with din_valid=0 on the parity+1 edge still occurs.
- Frame 0 with a flipped parity bit -> no cfg_we, err=1, busy=0; following valid frames are ignored; rst clears err.
- Count = NUM_CLB+1 (65) -> err=1 immediately after the 16th count bit, no writes. Count = 64 with 64 good frames -> last write addr 63, done=1.
- rst asserted at bit 20 of DATA in frame 3 -> all outputs 0 on the next edge, no write for frame 3. A new full load after release succeeds starting at addr 0.
